// File: rtl/xpt_sequencer_pkg.sv
// Shared encodings and defaults for the XPT step sequencer.
// State values are fixed so the FSM state can be read directly in debug dumps.
package xpt_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10,
    ST_ERR    = 2'b11
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_STALL = 2'b01;
  localparam logic [1:0] ERR_OVF   = 2'b10;

  localparam int DEF_MAX_STEP    = 31;
  localparam int DEF_STALL_LIMIT = 15;

endpackage

// File: rtl/xpt_sequencer_watchdog.sv
// Saturating count of consecutive stalled cycles; limit flag is a registered-count compare.
// No backpressure: the counter follows inc/clr each cycle, clr has priority.
module xpt_stall_watchdog
  import xpt_seq_pkg::*;
#(
  parameter int STALL_LIMIT = DEF_STALL_LIMIT,
  parameter int CW          = $clog2(STALL_LIMIT + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  logic [CW-1:0] r_cnt;

  assign o_at_limit = (r_cnt == CW'(STALL_LIMIT));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_at_limit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/xpt_sequencer.sv
// Control FSM for the XPT micro-step register; control outputs are combinational so XPT
// samples them at the same edge. Stall freezes XPT; halt is taken only at instruction end.
module xpt_sequencer
  import xpt_seq_pkg::*;
#(
  parameter int MAX_STEP    = DEF_MAX_STEP,
  parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Halt_Req,
  input  logic       Stall,
  input  logic       Last_Step,
  input  logic [4:0] XPT,
  output logic       PR_Reset_XPT,
  output logic       notPR_Halt_XPT,
  output logic       Instr_Done,
  output logic       Running,
  output logic [1:0] Err_Code
);

  state_t     r_state;
  state_t     w_next;
  logic       r_halt_pend;
  logic       w_halt_pend_nxt;
  logic [1:0] r_err;
  logic [1:0] w_err_nxt;
  logic       w_at_limit;
  logic       w_cnt_inc;
  logic       w_cnt_clr;

  // Counter only advances on a stalled cycle that stays in RUN; every other cycle clears it.
  assign w_cnt_clr = !w_cnt_inc;

  xpt_stall_watchdog #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_wdog (
    .i_clk     (Clk),
    .i_rst     (Reset),
    .i_inc     (w_cnt_inc),
    .i_clr     (w_cnt_clr),
    .o_at_limit(w_at_limit)
  );

  assign Running  = (r_state == ST_RUN);
  assign Err_Code = r_err;

  always_comb begin
    w_next          = r_state;
    w_halt_pend_nxt = r_halt_pend;
    w_err_nxt       = r_err;
    PR_Reset_XPT    = 1'b1;
    notPR_Halt_XPT  = 1'b0;
    Instr_Done      = 1'b0;
    w_cnt_inc       = 1'b0;
    case (r_state)
      ST_IDLE, ST_HALTED: begin
        if (Start) begin
          w_next          = ST_RUN;
          w_halt_pend_nxt = Halt_Req;
        end
      end
      ST_RUN: begin
        w_halt_pend_nxt = r_halt_pend | Halt_Req;
        if (Stall) begin
          PR_Reset_XPT = 1'b0;
          if (w_at_limit) begin
            w_next    = ST_ERR;
            w_err_nxt = ERR_STALL;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end else if (Last_Step) begin
          Instr_Done = 1'b1;
          if (r_halt_pend || Halt_Req) begin
            w_next          = ST_HALTED;
            w_halt_pend_nxt = 1'b0;
          end
        end else if (XPT == 5'(MAX_STEP)) begin
          w_next    = ST_ERR;
          w_err_nxt = ERR_OVF;
        end else begin
          PR_Reset_XPT   = 1'b0;
          notPR_Halt_XPT = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_halt_pend <= 1'b0;
      r_err       <= ERR_NONE;
    end else begin
      r_state     <= w_next;
      r_halt_pend <= w_halt_pend_nxt;
      r_err       <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_xpt_sequencer.sv
// Bench for xpt_sequencer: owns the XPT register, checks directed tables and a random run
// against an instruction-level model of the sequencer.
module tb_xpt_sequencer;

  localparam int MAXS = 31;
  localparam int LIM  = 15;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALTED = 2, M_ERR = 3;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0, Halt_Req = 1'b0, Stall = 1'b0, Last_Step = 1'b0;
  logic [4:0] XPT = 5'd0;
  logic       PR_Reset_XPT, notPR_Halt_XPT, Instr_Done, Running;
  logic [1:0] Err_Code;

  always #5 Clk = ~Clk;

  xpt_sequencer #(.MAX_STEP(MAXS), .STALL_LIMIT(LIM)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Start         (Start),
    .Halt_Req      (Halt_Req),
    .Stall         (Stall),
    .Last_Step     (Last_Step),
    .XPT           (XPT),
    .PR_Reset_XPT  (PR_Reset_XPT),
    .notPR_Halt_XPT(notPR_Halt_XPT),
    .Instr_Done    (Instr_Done),
    .Running       (Running),
    .Err_Code      (Err_Code)
  );

  typedef struct {
    logic       st, hr, sl, ls;
    logic       e_rst, e_inc, e_done, e_run;
    logic [1:0] e_err;
    logic [4:0] e_xpt;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Instruction-level model: mode, pending halt, length of the current stall run, error.
  int m_mode   = M_IDLE;
  bit m_halt   = 1'b0;
  int m_stalls = 0;
  int m_err    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic vec_t mkv(input int st, hr, sl, ls, r, i, d, run, e, x);
    vec_t v;
    v.st = st[0]; v.hr = hr[0]; v.sl = sl[0]; v.ls = ls[0];
    v.e_rst = r[0]; v.e_inc = i[0]; v.e_done = d[0]; v.e_run = run[0];
    v.e_err = e[1:0]; v.e_xpt = x[4:0];
    return v;
  endfunction

  function automatic void model_out(input logic sl, ls, output int r, i, d);
    r = 1; i = 0; d = 0;
    if (m_mode == M_RUN) begin
      if (sl) r = 0;
      else if (ls) d = 1;
      else if (int'(XPT) != MAXS) begin r = 0; i = 1; end
    end
  endfunction

  function automatic void model_adv(input logic st, hr, sl, ls, input int xb);
    case (m_mode)
      M_IDLE, M_HALTED: if (st) begin m_mode = M_RUN; m_halt = hr; m_stalls = 0; end
      M_RUN: begin
        m_halt = m_halt | hr;
        if (sl) begin
          m_stalls++;
          if (m_stalls > LIM) begin m_mode = M_ERR; m_err = 1; end
        end else begin
          m_stalls = 0;
          if (ls) begin
            if (m_halt) begin m_mode = M_HALTED; m_halt = 1'b0; end
          end else if (xb == MAXS) begin
            m_mode = M_ERR; m_err = 2;
          end
        end
      end
      default: ;
    endcase
  endfunction

  task automatic cycle_core(input vec_t v, input bit use_row);
    int   er, ei, ed, xb;
    logic pr, inc;
    @(negedge Clk);
    Start = v.st; Halt_Req = v.hr; Stall = v.sl; Last_Step = v.ls;
    #1;
    if (use_row) begin
      chk("row_xpt", int'(XPT), int'(v.e_xpt));
      chk("row_pr_reset", int'(PR_Reset_XPT), int'(v.e_rst));
      chk("row_not_halt", int'(notPR_Halt_XPT), int'(v.e_inc));
      chk("row_done", int'(Instr_Done), int'(v.e_done));
      chk("row_running", int'(Running), int'(v.e_run));
      chk("row_err", int'(Err_Code), int'(v.e_err));
    end else begin
      model_out(v.sl, v.ls, er, ei, ed);
      chk("pr_reset", int'(PR_Reset_XPT), er);
      chk("not_halt", int'(notPR_Halt_XPT), ei);
      chk("done", int'(Instr_Done), ed);
      chk("running", int'(Running), (m_mode == M_RUN) ? 1 : 0);
      chk("err", int'(Err_Code), m_err);
    end
    pr = PR_Reset_XPT; inc = notPR_Halt_XPT; xb = int'(XPT);
    @(posedge Clk);
    #1;
    cyc++;
    model_adv(v.st, v.hr, v.sl, v.ls, xb);
    if (pr) XPT = 5'd0;
    else if (inc) XPT = XPT + 5'd1;
  endtask

  task automatic run_cycle(input int st, hr, sl, ls);
    cycle_core(mkv(st, hr, sl, ls, 0, 0, 0, 0, 0, 0), 1'b0);
  endtask

  // Reset lands between edges so its effect must be visible without a clock.
  task automatic do_reset();
    @(negedge Clk);
    Start = 1'b0; Halt_Req = 1'b0; Stall = 1'b0; Last_Step = 1'b0;
    #1;
    Reset = 1'b1;
    #1;
    chk("rst_pr_reset", int'(PR_Reset_XPT), 1);
    chk("rst_not_halt", int'(notPR_Halt_XPT), 0);
    chk("rst_done", int'(Instr_Done), 0);
    chk("rst_running", int'(Running), 0);
    chk("rst_err", int'(Err_Code), 0);
    @(posedge Clk);
    #1;
    cyc++;
    XPT = 5'd0;
    m_mode = M_IDLE; m_halt = 1'b0; m_stalls = 0; m_err = 0;
    Reset = 1'b0;
  endtask

  vec_t tab[14];

  initial begin
    // Start; 4-step instruction; then stall at XPT 2 with and without Last_Step.
    tab[0]  = mkv(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tab[1]  = mkv(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    tab[2]  = mkv(0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
    tab[3]  = mkv(0, 0, 0, 0, 0, 1, 0, 1, 0, 2);
    tab[4]  = mkv(0, 0, 0, 1, 1, 0, 1, 1, 0, 3);
    tab[5]  = mkv(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    tab[6]  = mkv(0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
    tab[7]  = mkv(0, 0, 1, 0, 0, 0, 0, 1, 0, 2);
    tab[8]  = mkv(0, 0, 1, 0, 0, 0, 0, 1, 0, 2);
    tab[9]  = mkv(0, 0, 1, 0, 0, 0, 0, 1, 0, 2);
    tab[10] = mkv(0, 0, 1, 0, 0, 0, 0, 1, 0, 2);
    tab[11] = mkv(0, 0, 1, 1, 0, 0, 0, 1, 0, 2);
    tab[12] = mkv(0, 0, 0, 1, 1, 0, 1, 1, 0, 2);
    tab[13] = mkv(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);

    do_reset();
    for (int k = 0; k < 14; k++) cycle_core(tab[k], 1'b1);

    // Halt requested at XPT 1, honoured only when the instruction ends at XPT 4.
    run_cycle(0, 1, 0, 0);
    run_cycle(0, 0, 0, 0);
    run_cycle(0, 0, 0, 0);
    run_cycle(0, 0, 0, 1);
    chk("halt_running", int'(Running), 0);
    chk("halt_xpt", int'(XPT), 0);
    run_cycle(0, 0, 0, 0);
    run_cycle(1, 0, 0, 0);
    chk("resume_running", int'(Running), 1);
    chk("resume_xpt", int'(XPT), 0);
    run_cycle(0, 0, 0, 0);
    run_cycle(0, 0, 0, 1);
    chk("no_halt_running", int'(Running), 1);
    run_cycle(0, 1, 0, 1);
    chk("halt_same_cycle", int'(Running), 0);

    // Single step: exactly one instruction then back to HALTED.
    run_cycle(1, 1, 0, 0);
    chk("step_running", int'(Running), 1);
    run_cycle(0, 0, 0, 0);
    run_cycle(0, 0, 0, 0);
    run_cycle(0, 0, 0, 1);
    chk("step_halted", int'(Running), 0);

    // Stall timeout: 15 stalled cycles are legal, the 16th is not.
    run_cycle(1, 0, 0, 0);
    repeat (15) run_cycle(0, 0, 1, 0);
    chk("stall15_err", int'(Err_Code), 0);
    chk("stall15_running", int'(Running), 1);
    run_cycle(0, 0, 1, 0);
    chk("stall16_err", int'(Err_Code), 1);
    chk("stall16_pr_reset", int'(PR_Reset_XPT), 1);
    run_cycle(1, 1, 0, 0);
    chk("err_ignores_start", int'(Running), 0);
    chk("err_sticky", int'(Err_Code), 1);

    // Overflow: no Last_Step, XPT walks to 31 and is parked.
    do_reset();
    run_cycle(1, 0, 0, 0);
    repeat (32) run_cycle(0, 0, 0, 0);
    chk("ovf_err", int'(Err_Code), 2);
    chk("ovf_xpt", int'(XPT), 0);
    chk("ovf_running", int'(Running), 0);

    // Reset in the middle of an instruction.
    do_reset();
    run_cycle(1, 0, 0, 0);
    repeat (5) run_cycle(0, 0, 0, 0);
    chk("mid_xpt_before", int'(XPT), 5);
    do_reset();
    chk("mid_xpt_after", int'(XPT), 0);

    begin
      int tgt = 3, burst = 0, err_age = 0;
      for (int k = 0; k < 3000; k++) begin
        int st, hr, sl, ls;
        if (m_mode == M_ERR) err_age++;
        else err_age = 0;
        if (err_age > 4 || $urandom_range(0, 299) == 0) do_reset();
        if (burst == 0 && $urandom_range(0, 249) == 0) burst = int'($urandom_range(10, 20));
        sl = (burst > 0 || $urandom_range(0, 3) == 0) ? 1 : 0;
        if (burst > 0) burst--;
        if (XPT == 5'd0 && sl == 0)
          tgt = ($urandom_range(0, 39) == 0) ? 99 : int'($urandom_range(0, 6));
        ls = (int'(XPT) == tgt || $urandom_range(0, 29) == 0) ? 1 : 0;
        st = ($urandom_range(0, 3) == 0) ? 1 : 0;
        hr = ($urandom_range(0, 9) == 0) ? 1 : 0;
        run_cycle(st, hr, sl, ls);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
